// File: rtl/cover_actuator_if.sv
// Command/status bundle between the bakery controller, the pressure model and
// the cover actuator: tick enable, commands in, position and zone flags out.
interface cover_actuator_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             X_cover;
  logic             S_pressure_high;
  logic             S_pressure_medium;
  logic [WIDTH-1:0] S_cover;
  logic             S_cover_closed;
  logic             S_cover_leaky;
  logic             S_cover_opened;
  logic             S_cover_fully_opened;
  logic             S_cover_moving;
  logic             S_relief_active;

  modport master (
    output en, X_cover,
    output S_pressure_high, S_pressure_medium,
    input  S_cover, S_cover_closed, S_cover_leaky,
    input  S_cover_opened, S_cover_fully_opened,
    input  S_cover_moving, S_relief_active
  );

  modport slave (
    input  en, X_cover,
    input  S_pressure_high, S_pressure_medium,
    output S_cover, S_cover_closed, S_cover_leaky,
    output S_cover_opened, S_cover_fully_opened,
    output S_cover_moving, S_relief_active
  );
endinterface

// File: rtl/cover_actuator.sv
// Pressure-vessel cover actuator plant: saturating position integrator,
// reversal dead-time, overpressure relief hold and hysteretic zone FSM.
// Ports: clk, rst (async, active-high), bus (slave side of
// cover_actuator_if: en, X_cover, S_pressure_high/medium in; S_cover,
// zone flags, S_cover_moving, S_relief_active out).
module cover_actuator #(
  parameter int WIDTH      = 16,
  parameter int RATE_OPEN  = 2517,
  parameter int RATE_CLOSE = 2523,
  parameter int T_FULL     = 16384,
  parameter int T_OPEN     = 32768,
  parameter int T_LEAK     = 49152,
  parameter int HYST       = 1024,
  parameter int DEADTIME   = 2,
  parameter int HOLD       = 4
) (
  input logic             clk,
  input logic             rst,
  cover_actuator_if.slave bus
);

  localparam int DW = $clog2(DEADTIME + 2);
  localparam int HW = $clog2(HOLD + 2);

  localparam logic [WIDTH:0] R_OPEN  = (WIDTH+1)'(RATE_OPEN);
  localparam logic [WIDTH:0] R_CLOSE = (WIDTH+1)'(RATE_CLOSE);
  localparam logic [WIDTH:0] TU_FULL = (WIDTH+1)'(T_FULL);
  localparam logic [WIDTH:0] TU_OPEN = (WIDTH+1)'(T_OPEN);
  localparam logic [WIDTH:0] TU_LEAK = (WIDTH+1)'(T_LEAK);
  localparam logic [WIDTH:0] TD_FULL = (WIDTH+1)'(T_FULL - HYST);
  localparam logic [WIDTH:0] TD_OPEN = (WIDTH+1)'(T_OPEN - HYST);
  localparam logic [WIDTH:0] TD_LEAK = (WIDTH+1)'(T_LEAK - HYST);

  typedef enum logic [1:0] {
    Z_FULL,
    Z_OPEN,
    Z_LEAKY,
    Z_CLOSED
  } zone_e;

  logic [WIDTH-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [DW-1:0]    dead_q, dead_d;
  logic [HW-1:0]    hold_q, hold_d;
  zone_e            zone_q, zone_d;

  logic [WIDTH:0]   pos_x, sub_x, add_x;
  logic             force_open;
  logic             xe;
  logic             at_limit;
  logic             moving;

  // dir/xe encoding follows X_cover: 1 = open, 0 = close.
  always_comb begin
    pos_x = {1'b0, pos_q};
    sub_x = pos_x - R_OPEN;
    add_x = pos_x + R_CLOSE;
    force_open = bus.S_pressure_high
               | (hold_q != '0)
               | ((zone_q == Z_CLOSED)
                  & bus.S_pressure_medium);
    xe = force_open | bus.X_cover;
    at_limit = xe ? (pos_q == '0)
                  : (pos_q == {WIDTH{1'b1}});
    moving = (xe == dir_q)
           & (dead_q == '0)
           & ~at_limit;
  end

  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    dead_d = dead_q;
    hold_d = hold_q;
    zone_d = zone_q;
    if (bus.en) begin
      if (xe != dir_q) begin
        dir_d  = xe;
        dead_d = DW'(DEADTIME);
      end else if (dead_q != '0) begin
        dead_d = dead_q - DW'(1);
      end else if (xe) begin
        // borrow out of the extra bit means we passed fully open
        pos_d = sub_x[WIDTH] ? '0 : sub_x[WIDTH-1:0];
      end else begin
        pos_d = add_x[WIDTH] ? '1 : add_x[WIDTH-1:0];
      end

      if (bus.S_pressure_high)
        hold_d = HW'(HOLD);
      else if (hold_q != '0)
        hold_d = hold_q - HW'(1);

      // Zone follows the registered position, one step per tick.
      unique case (zone_q)
        Z_FULL: begin
          if (pos_x >= TU_FULL) zone_d = Z_OPEN;
        end
        Z_OPEN: begin
          if (pos_x >= TU_OPEN)
            zone_d = Z_LEAKY;
          else if (pos_x < TD_FULL)
            zone_d = Z_FULL;
        end
        Z_LEAKY: begin
          if (pos_x >= TU_LEAK)
            zone_d = Z_CLOSED;
          else if (pos_x < TD_OPEN)
            zone_d = Z_OPEN;
        end
        Z_CLOSED: begin
          if (pos_x < TD_LEAK) zone_d = Z_LEAKY;
        end
        default: zone_d = Z_FULL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q  <= '0;
      dir_q  <= 1'b1;
      dead_q <= '0;
      hold_q <= '0;
      zone_q <= Z_FULL;
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      dead_q <= dead_d;
      hold_q <= hold_d;
      zone_q <= zone_d;
    end
  end

  assign bus.S_cover              = pos_q;
  assign bus.S_cover_closed       = (zone_q == Z_CLOSED);
  assign bus.S_cover_leaky        = (zone_q == Z_LEAKY);
  assign bus.S_cover_opened       = (zone_q == Z_OPEN)
                                  | (zone_q == Z_FULL);
  assign bus.S_cover_fully_opened = (zone_q == Z_FULL);
  assign bus.S_cover_moving       = moving;
  assign bus.S_relief_active      = bus.S_pressure_high
                                  | (hold_q != '0);

endmodule

// File: tb/tb_cover_actuator.sv
// Directed bench for cover_actuator: vector table for close/open sweeps,
// hand sequences for relief hold, en-low freeze and async reset.
module tb_cover_actuator;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cover_actuator_if #(.WIDTH(16)) bus ();

  cover_actuator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // flag order: closed, leaky, opened, fully_opened, moving, relief
  typedef struct {
    int          n;
    logic        x;
    logic [15:0] pos;
    logic [5:0]  fl;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(int n, logic x,
                              logic [15:0] p,
                              logic [5:0] f);
    vec_t v;
    v.n = n;
    v.x = x;
    v.pos = p;
    v.fl = f;
    return v;
  endfunction

  function automatic logic [5:0] flags();
    return {bus.S_cover_closed, bus.S_cover_leaky,
            bus.S_cover_opened, bus.S_cover_fully_opened,
            bus.S_cover_moving, bus.S_relief_active};
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(string name,
                           int p, logic [5:0] f);
    chk({name, " pos"}, int'(bus.S_cover), p);
    chk({name, " flags"}, int'(flags()), int'(f));
  endtask

  initial begin
    // closing sweep from reset
    tbl[0]  = mk(1, 1'b0, 16'd0,     6'b001100);
    tbl[1]  = mk(2, 1'b0, 16'd0,     6'b001110);
    tbl[2]  = mk(1, 1'b0, 16'd2523,  6'b001110);
    tbl[3]  = mk(6, 1'b0, 16'd17661, 6'b001110);
    tbl[4]  = mk(1, 1'b0, 16'd20184, 6'b001010);
    tbl[5]  = mk(5, 1'b0, 16'd32799, 6'b001010);
    tbl[6]  = mk(1, 1'b0, 16'd35322, 6'b010010);
    tbl[7]  = mk(6, 1'b0, 16'd50460, 6'b010010);
    tbl[8]  = mk(1, 1'b0, 16'd52983, 6'b100010);
    tbl[9]  = mk(4, 1'b0, 16'd63075, 6'b100010);
    tbl[10] = mk(1, 1'b0, 16'd65535, 6'b100000);
    tbl[11] = mk(2, 1'b0, 16'd65535, 6'b100000);
    // opening sweep from sealed
    tbl[12] = mk(1, 1'b1, 16'd65535, 6'b100000);
    tbl[13] = mk(2, 1'b1, 16'd65535, 6'b100010);
    tbl[14] = mk(7, 1'b1, 16'd47916, 6'b100010);
    tbl[15] = mk(1, 1'b1, 16'd45399, 6'b010010);
    tbl[16] = mk(6, 1'b1, 16'd30297, 6'b010010);
    tbl[17] = mk(1, 1'b1, 16'd27780, 6'b001010);
    tbl[18] = mk(5, 1'b1, 16'd15195, 6'b001010);
    tbl[19] = mk(1, 1'b1, 16'd12678, 6'b001110);
    tbl[20] = mk(5, 1'b1, 16'd93,    6'b001110);
    tbl[21] = mk(1, 1'b1, 16'd0,     6'b001100);
    tbl[22] = mk(1, 1'b1, 16'd0,     6'b001100);

    rst = 1'b1;
    bus.en = 1'b0;
    bus.X_cover = 1'b1;
    bus.S_pressure_high = 1'b0;
    bus.S_pressure_medium = 1'b0;
    repeat (2) tick();
    chk_state("reset", 0, 6'b001100);
    rst = 1'b0;
    bus.en = 1'b1;

    for (int i = 0; i < 23; i++) begin
      bus.X_cover = tbl[i].x;
      repeat (tbl[i].n) tick();
      chk_state($sformatf("vec%0d", i),
                int'(tbl[i].pos), tbl[i].fl);
    end

    // relief hold with medium pressure while sealed
    bus.X_cover = 1'b0;
    repeat (29) tick();
    chk_state("reseal", 65535, 6'b100000);
    bus.S_pressure_medium = 1'b1;
    bus.S_pressure_high = 1'b1;
    #1;
    chk("relief comb", int'(bus.S_relief_active), 1);
    tick();
    bus.S_pressure_high = 1'b0;
    chk_state("hold A", 65535, 6'b100001);
    tick();
    chk_state("hold B", 65535, 6'b100001);
    tick();
    chk_state("hold C", 65535, 6'b100011);
    tick();
    chk_state("hold D", 63018, 6'b100011);
    tick();
    chk_state("hold E", 60501, 6'b100010);
    repeat (5) tick();
    chk_state("med open", 47916, 6'b100010);
    tick();
    chk_state("med leaky", 45399, 6'b010000);
    tick();
    chk_state("med rev", 45399, 6'b010000);
    tick();
    chk_state("med dead", 45399, 6'b010000);
    tick();
    chk_state("med dead0", 45399, 6'b010010);
    tick();
    chk_state("med close", 47922, 6'b010010);
    bus.S_pressure_medium = 1'b0;

    // en low freezes everything
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.S_pressure_high = ~bus.S_pressure_high;
      tick();
      if (bus.S_pressure_high)
        chk("freeze relief", int'(bus.S_relief_active), 1);
    end
    bus.S_pressure_high = 1'b0;
    #1;
    chk_state("freeze", 47922, 6'b010010);
    bus.en = 1'b1;
    tick();
    chk_state("thaw", 50445, 6'b010010);

    // async reset mid dead-time with hold armed
    bus.X_cover = 1'b1;
    bus.S_pressure_high = 1'b1;
    tick();
    bus.S_pressure_high = 1'b0;
    chk_state("pre rst", 50445, 6'b100001);
    #3;
    rst = 1'b1;
    #1;
    chk_state("async rst", 0, 6'b001100);
    #2;
    rst = 1'b0;
    tick();
    chk_state("post rst", 0, 6'b001100);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
